// File: rtl/imm_ext_pkg.sv
// imm_ext_pkg: shared types and constants for the immediate-extension stage.
//   MODE_*       : extension-mode encodings carried on in_mode/out_mode
//   imm_mode_t   : 2-bit mode type
//   occ_state_t  : occupancy of the output/skid register pair
//   occ_count()  : number of valid entries held in a given occupancy state
package imm_ext_pkg;

    typedef logic [1:0] imm_mode_t;

    localparam imm_mode_t MODE_SIGN   = 2'd0;
    localparam imm_mode_t MODE_ZERO   = 2'd1;
    localparam imm_mode_t MODE_LUI    = 2'd2;
    localparam imm_mode_t MODE_BRANCH = 2'd3;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_state_t;

    function automatic logic [1:0] occ_count(input occ_state_t s);
        case (s)
            OCC_ONE:  return 2'd1;
            OCC_FULL: return 2'd2;
            default:  return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/imm_ext_core.sv
// imm_ext_core: combinational 4-mode immediate extender.
//   imm  [IN_W]  : raw immediate
//   mode [2]     : SIGN / ZERO / LUI / BRANCH
//   ext  [OUT_W] : extended result
module imm_ext_core
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic [IN_W-1:0]  imm,
    input  imm_mode_t        mode,
    output logic [OUT_W-1:0] ext
);

    // Branch mode shifts a sign-extended value left by two, so at least two
    // bits of headroom above the immediate are needed.
    if (OUT_W < IN_W + 2) begin : g_bad_width
        $error("imm_ext_core: OUT_W must be at least IN_W+2");
    end

    logic [OUT_W-1:0] sext;
    logic [OUT_W-1:0] zext;
    logic [OUT_W-1:0] upper;

    assign sext  = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
    assign zext  = {{(OUT_W-IN_W){1'b0}}, imm};
    assign upper = {imm, {(OUT_W-IN_W){1'b0}}};

    always_comb begin
        ext = sext;
        case (mode)
            MODE_SIGN:   ext = sext;
            MODE_ZERO:   ext = zext;
            MODE_LUI:    ext = upper;
            MODE_BRANCH: ext = sext << 2;  // word offset; top bits fall off
            default:     ext = sext;
        endcase
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: registered immediate-extension stage with a 2-entry skid
// buffer (output register OR + skid register SK) and flush support.
//   clk, rst            : clock, synchronous active-high reset
//   flush               : drop every held entry (and any same-cycle input)
//   in_valid/in_ready   : input handshake; in_ready depends only on state
//   in_imm/in_mode/in_tag : raw immediate, extension mode, sideband tag
//   out_valid/out_ready : output handshake, data driven straight from OR
//   out_imm/out_tag/out_mode : extended immediate and its sideband
//   drop_cnt            : saturating count of entries discarded by flush
module imm_extend_pipe
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  imm_mode_t        in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_imm,
    output logic [TAG_W-1:0] out_tag,
    output imm_mode_t        out_mode,
    output logic [7:0]       drop_cnt
);

    occ_state_t state, state_next;

    logic [OUT_W-1:0] in_ext;
    logic [OUT_W-1:0] or_imm, sk_imm;
    logic [TAG_W-1:0] or_tag, sk_tag;
    imm_mode_t        or_mode, sk_mode;

    logic accept, pop;
    logic load_or_in, load_sk_in, move_sk;
    logic [8:0] drop_sum;
    logic [7:0] drop_sat;

    // Extension happens before the register so out_* is a pure flop output.
    imm_ext_core #(.IN_W(IN_W), .OUT_W(OUT_W)) u_core (
        .imm  (in_imm),
        .mode (in_mode),
        .ext  (in_ext)
    );

    assign in_ready  = (state != OCC_FULL);
    assign out_valid = (state != OCC_EMPTY);
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign out_imm  = or_imm;
    assign out_tag  = or_tag;
    assign out_mode = or_mode;

    always_ff @(posedge clk) begin
        if (rst || flush) state <= OCC_EMPTY;
        else              state <= state_next;
    end

    always_comb begin
        state_next = state;
        load_or_in = 1'b0;
        load_sk_in = 1'b0;
        move_sk    = 1'b0;
        case (state)
            OCC_EMPTY: begin
                if (accept) begin
                    state_next = OCC_ONE;
                    load_or_in = 1'b1;
                end
            end
            OCC_ONE: begin
                if (accept && pop) begin
                    load_or_in = 1'b1;        // OR drains and refills
                end else if (accept) begin
                    state_next = OCC_FULL;
                    load_sk_in = 1'b1;        // OR stalled, park in SK
                end else if (pop) begin
                    state_next = OCC_EMPTY;
                end
            end
            OCC_FULL: begin
                if (pop) begin
                    state_next = OCC_ONE;
                    move_sk    = 1'b1;
                end
            end
            default: state_next = OCC_EMPTY;
        endcase
        // Flush/reset override everything, including data movement.
        if (rst || flush) begin
            load_or_in = 1'b0;
            load_sk_in = 1'b0;
            move_sk    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            or_imm  <= '0;
            or_tag  <= '0;
            or_mode <= MODE_SIGN;
        end else if (load_or_in) begin
            or_imm  <= in_ext;
            or_tag  <= in_tag;
            or_mode <= in_mode;
        end else if (move_sk) begin
            or_imm  <= sk_imm;
            or_tag  <= sk_tag;
            or_mode <= sk_mode;
        end
    end

    // SK needs no reset: it is only read after being written while FULL.
    always_ff @(posedge clk) begin
        if (load_sk_in) begin
            sk_imm  <= in_ext;
            sk_tag  <= in_tag;
            sk_mode <= in_mode;
        end
    end

    // A flushed cycle loses the held entries plus any offered input.
    always_comb begin
        drop_sum = {1'b0, drop_cnt} + 9'(occ_count(state)) + 9'(in_valid);
        drop_sat = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst)        drop_cnt <= '0;
        else if (flush) drop_cnt <= drop_sat;
    end

endmodule

// File: tb/tb_imm_extend_pipe.sv
module tb_imm_extend_pipe;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [15:0] in_imm;
    logic [1:0]  in_mode, out_mode;
    logic [4:0]  in_tag, out_tag;
    logic [31:0] out_imm;
    logic [7:0]  drop_cnt;

    imm_extend_pipe #(.IN_W(16), .OUT_W(32), .TAG_W(5)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_imm(in_imm), .in_mode(in_mode), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_imm(out_imm), .out_tag(out_tag), .out_mode(out_mode),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] imm;
        logic [4:0]  tag;
        logic [1:0]  mode;
    } ent_t;

    ent_t q[$];       // reference: in-order FIFO of capacity 2
    int   m_drop = 0;

    function automatic logic [31:0] ref_ext(input logic [15:0] imm, input logic [1:0] mode);
        longint s;
        s = longint'($signed(imm));
        case (mode)
            2'd0:    return 32'(s);
            2'd1:    return {16'h0, imm};
            2'd2:    return 32'(imm) * 32'd65536;
            default: return 32'(s * 4);
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
        chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
        chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
        if (q.size() > 0) begin
            chk("out_imm", out_imm, q[0].imm);
            chk("out_tag", 32'(out_tag), 32'(q[0].tag));
            chk("out_mode", 32'(out_mode), 32'(q[0].mode));
        end
    endtask

    // One clock: drive inputs, check the pre-edge state, advance the model.
    task automatic cycle(input logic r, input logic f, input logic iv,
                         input logic [15:0] imm, input logic [1:0] mode,
                         input logic [4:0] tag, input logic ordy);
        logic acc, pp;
        ent_t e;
        rst = r; flush = f; in_valid = iv; in_imm = imm; in_mode = mode;
        in_tag = tag; out_ready = ordy;
        #1;
        check_model();
        @(posedge clk);
        if (r) begin
            q.delete();
            m_drop = 0;
        end else if (f) begin
            m_drop = m_drop + q.size() + int'(iv);
            if (m_drop > 255) m_drop = 255;
            q.delete();
        end else begin
            acc = iv && (q.size() < 2);
            pp  = (q.size() > 0) && ordy;
            if (pp) void'(q.pop_front());
            if (acc) begin
                e.imm = ref_ext(imm, mode); e.tag = tag; e.mode = mode;
                q.push_back(e);
            end
        end
        @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_drop_cnt"}, 32'(drop_cnt), 32'd0);
        chk({tag, "_out_imm"}, out_imm, 32'd0);
        chk({tag, "_out_tag"}, 32'(out_tag), 32'd0);
        chk({tag, "_out_mode"}, 32'(out_mode), 32'd0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_imm = '0; in_mode = '0; in_tag = '0;
        @(negedge clk);
        cycle(1, 0, 0, 16'h0, 2'd0, 5'd0, 0);
        cycle(1, 0, 1, 16'h5555, 2'd1, 5'd7, 1);
        chk_reset_vals("reset");

        // Extension modes, one-cycle latency, tags preserved.
        cycle(0, 0, 1, 16'h8001, 2'd0, 5'd3, 1);
        chk("sign_8001", out_imm, 32'hFFFF8001);
        chk("sign_tag", 32'(out_tag), 32'd3);
        cycle(0, 0, 1, 16'h8001, 2'd1, 5'd4, 1);
        chk("zero_8001", out_imm, 32'h00008001);
        chk("zero_tag", 32'(out_tag), 32'd4);
        cycle(0, 0, 1, 16'h1234, 2'd2, 5'd5, 1);
        chk("lui_1234", out_imm, 32'h12340000);
        cycle(0, 0, 1, 16'hFFFF, 2'd3, 5'd6, 1);
        chk("br_ffff", out_imm, 32'hFFFFFFFC);
        cycle(0, 0, 1, 16'h7FFF, 2'd3, 5'd7, 1);
        chk("br_7fff", out_imm, 32'h0001FFFC);
        chk("br_mode", 32'(out_mode), 32'd3);
        cycle(0, 0, 0, 16'h0, 2'd0, 5'd0, 1);
        chk("drained", 32'(out_valid), 32'd0);

        // Stall stream of three entries.
        cycle(0, 0, 1, 16'h0011, 2'd1, 5'd1, 0);
        chk("stall_a_or", out_imm, 32'h00000011);
        chk("stall_a_rdy", 32'(in_ready), 32'd1);
        cycle(0, 0, 1, 16'h0022, 2'd1, 5'd2, 0);
        chk("stall_b_rdy", 32'(in_ready), 32'd0);
        cycle(0, 0, 1, 16'h0033, 2'd1, 5'd3, 0);
        chk("stall_c_held", out_imm, 32'h00000011);
        chk("stall_c_rdy", 32'(in_ready), 32'd0);
        cycle(0, 0, 1, 16'h0033, 2'd1, 5'd3, 1);
        chk("drain_b", out_imm, 32'h00000022);
        chk("drain_b_tag", 32'(out_tag), 32'd2);
        cycle(0, 0, 1, 16'h0033, 2'd1, 5'd3, 1);
        chk("drain_c", out_imm, 32'h00000033);
        chk("drain_c_rdy", 32'(in_ready), 32'd1);
        cycle(0, 0, 0, 16'h0, 2'd0, 5'd0, 1);
        chk("drain_empty", 32'(out_valid), 32'd0);

        // Flush while FULL with a same-cycle input.
        cycle(0, 0, 1, 16'h0101, 2'd0, 5'd1, 0);
        cycle(0, 0, 1, 16'h0202, 2'd0, 5'd2, 0);
        cycle(0, 1, 1, 16'h0303, 2'd0, 5'd3, 1);
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_rdy", 32'(in_ready), 32'd1);
        chk("flush_drop", 32'(drop_cnt), 32'd3);

        // Reset mid-stream.
        cycle(0, 0, 1, 16'hABCD, 2'd2, 5'd9, 0);
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        cycle(1, 0, 1, 16'h1111, 2'd1, 5'd1, 1);
        chk_reset_vals("mid_rst");

        // Randomized traffic against the FIFO model.
        for (int i = 0; i < 400; i++) begin
            cycle(0, ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
                  16'($urandom), 2'($urandom), 5'($urandom),
                  ($urandom_range(0, 2) != 0));
        end
        cycle(0, 0, 0, 16'h0, 2'd0, 5'd0, 1);

        // Drop counter saturation.
        cycle(1, 0, 0, 16'h0, 2'd0, 5'd0, 0);
        for (int i = 0; i < 300; i++) begin
            cycle(0, 1, 1, 16'($urandom), 2'($urandom), 5'($urandom), 0);
            if (i == 99) chk("drop_100", 32'(drop_cnt), 32'd100);
        end
        chk("drop_sat", 32'(drop_cnt), 32'd255);
        cycle(0, 0, 0, 16'h0, 2'd0, 5'd0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
